// File: rtl/acc_bank_pkg.sv
// Shared constants and types for the Int1 accumulator/system-register bank.
package acc_bank_pkg;

  localparam int DW          = 32;
  localparam int NACC        = 16;
  localparam int NSYS        = 8;
  localparam int WEN_VLD_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_ACK  = 2'b10
  } host_st_e;

  typedef struct packed {
    logic          we;
    logic          sel;
    logic [3:0]    addr;
    logic [DW-1:0] wdata;
  } host_req_t;

endpackage

// File: rtl/acc_bank_host_if1.sv
// Host/debug port: four-phase handshake FSM, request capture and read-data mux.
// state | meaning
// IDLE  | waiting for host_req, capturing we/sel/addr/wdata on entry to XFER
// XFER  | perform read or write; acc writes wait for a cycle free of pipeline/clear
// ACK   | ack high, hold until host drops req
module acc_bank_host_if1
  import acc_bank_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      host_req_i,
  input  logic                      host_we_i,
  input  logic                      host_sel_i,
  input  logic [3:0]                host_addr_i,
  input  logic [DW-1:0]             host_wdata_i,
  input  logic                      pipe_busy_i,
  input  logic [NACC-1:0][DW-1:0]   acc_i,
  input  logic [NSYS-1:0][DW-1:0]   sys_i,
  output logic                      acc_we_o,
  output logic                      sys_we_o,
  output logic [3:0]                wr_addr_o,
  output logic [DW-1:0]             wr_data_o,
  output logic                      host_ack_o,
  output logic [DW-1:0]             host_rdata_o
);

  host_st_e      state_q, state_d;
  host_req_t     req_q, req_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] rd_mux;
  logic          in_xfer_wr;

  always_comb begin
    rd_mux = '0;
    if (req_q.sel) begin
      if (!req_q.addr[3]) rd_mux = sys_i[req_q.addr[2:0]];
    end else begin
      rd_mux = acc_i[req_q.addr];
    end
  end

  assign in_xfer_wr = (state_q == ST_XFER) && req_q.we;
  assign acc_we_o   = in_xfer_wr && !req_q.sel && !pipe_busy_i;
  // sysreg00/01 are hardware counters, so only 02..07 accept host data
  assign sys_we_o   = in_xfer_wr && req_q.sel && !req_q.addr[3] &&
                      (req_q.addr[2:0] >= 3'd2);
  assign wr_addr_o  = req_q.addr;
  assign wr_data_o  = req_q.wdata;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host_req_i) begin
          req_d.we    = host_we_i;
          req_d.sel   = host_sel_i;
          req_d.addr  = host_addr_i;
          req_d.wdata = host_wdata_i;
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!req_q.we) begin
          rdata_d = rd_mux;
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else if (req_q.sel || !pipe_busy_i) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end
      end
      ST_ACK: begin
        if (!host_req_i) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign host_ack_o   = ack_q;
  assign host_rdata_o = rdata_q;

endmodule

// File: rtl/acc_bank1.sv
// Int1 accumulator and system-register file: pipeline write port, bulk clear,
// cycle/write counters and a host debug port.
module acc_bank1 #(
  parameter int DW   = acc_bank_pkg::DW,
  parameter int NACC = acc_bank_pkg::NACC,
  parameter int NSYS = acc_bank_pkg::NSYS
) (
  input  logic          clk_i_accbank,
  input  logic          rst_n_i_accbank,
  input  logic [4:0]    acc_wen_vctr_i_accbank,
  input  logic [DW-1:0] acc_wdata_i_accbank,
  input  logic          clr_i_accbank,
  input  logic          host_req_i_accbank,
  input  logic          host_we_i_accbank,
  input  logic          host_sel_i_accbank,
  input  logic [3:0]    host_addr_i_accbank,
  input  logic [DW-1:0] host_wdata_i_accbank,
  output logic          host_ack_o_accbank,
  output logic [DW-1:0] host_rdata_o_accbank,
  output logic [DW-1:0] acc00_o_accbank,
  output logic [DW-1:0] acc01_o_accbank,
  output logic [DW-1:0] acc02_o_accbank,
  output logic [DW-1:0] acc03_o_accbank,
  output logic [DW-1:0] acc04_o_accbank,
  output logic [DW-1:0] acc05_o_accbank,
  output logic [DW-1:0] acc06_o_accbank,
  output logic [DW-1:0] acc07_o_accbank,
  output logic [DW-1:0] acc08_o_accbank,
  output logic [DW-1:0] acc09_o_accbank,
  output logic [DW-1:0] acc10_o_accbank,
  output logic [DW-1:0] acc11_o_accbank,
  output logic [DW-1:0] acc12_o_accbank,
  output logic [DW-1:0] acc13_o_accbank,
  output logic [DW-1:0] acc14_o_accbank,
  output logic [DW-1:0] acc15_o_accbank,
  output logic [DW-1:0] sysreg00_o_accbank,
  output logic [DW-1:0] sysreg01_o_accbank,
  output logic [DW-1:0] sysreg02_o_accbank,
  output logic [DW-1:0] sysreg03_o_accbank,
  output logic [DW-1:0] sysreg04_o_accbank,
  output logic [DW-1:0] sysreg05_o_accbank,
  output logic [DW-1:0] sysreg06_o_accbank,
  output logic [DW-1:0] sysreg07_o_accbank
);

  import acc_bank_pkg::*;

  logic [NACC-1:0][DW-1:0] acc_q, acc_d;
  logic [NSYS-1:2][DW-1:0] gp_q, gp_d;
  logic [DW-1:0]           cyc_q, cyc_d;
  logic [DW-1:0]           wr_cnt_q, wr_cnt_d;
  logic [NSYS-1:0][DW-1:0] sys_view;

  logic          pipe_wr;
  logic [3:0]    pipe_idx;
  logic          host_acc_we, host_sys_we;
  logic [3:0]    host_wr_addr;
  logic [DW-1:0] host_wr_data;

  assign pipe_wr  = acc_wen_vctr_i_accbank[WEN_VLD_BIT];
  assign pipe_idx = acc_wen_vctr_i_accbank[WEN_VLD_BIT-1:0];
  assign sys_view = {gp_q, wr_cnt_q, cyc_q};

  acc_bank_host_if1 u_host_if (
    .clk          (clk_i_accbank),
    .rst_n        (rst_n_i_accbank),
    .host_req_i   (host_req_i_accbank),
    .host_we_i    (host_we_i_accbank),
    .host_sel_i   (host_sel_i_accbank),
    .host_addr_i  (host_addr_i_accbank),
    .host_wdata_i (host_wdata_i_accbank),
    .pipe_busy_i  (pipe_wr | clr_i_accbank),
    .acc_i        (acc_q),
    .sys_i        (sys_view),
    .acc_we_o     (host_acc_we),
    .sys_we_o     (host_sys_we),
    .wr_addr_o    (host_wr_addr),
    .wr_data_o    (host_wr_data),
    .host_ack_o   (host_ack_o_accbank),
    .host_rdata_o (host_rdata_o_accbank)
  );

  // Clear beats the pipeline, which beats the host; host_acc_we is already
  // masked by pipe_busy so the host never collides with either.
  always_comb begin
    acc_d = acc_q;
    if (clr_i_accbank) begin
      acc_d = '0;
    end else if (pipe_wr) begin
      acc_d[pipe_idx] = acc_wdata_i_accbank;
    end else if (host_acc_we) begin
      acc_d[host_wr_addr] = host_wr_data;
    end
  end

  always_comb begin
    gp_d = gp_q;
    if (host_sys_we) gp_d[host_wr_addr[2:0]] = host_wr_data;
  end

  always_comb begin
    cyc_d    = cyc_q + 1'b1;
    wr_cnt_d = wr_cnt_q;
    if (pipe_wr && !clr_i_accbank && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i_accbank or negedge rst_n_i_accbank) begin
    if (!rst_n_i_accbank) begin
      acc_q    <= '0;
      gp_q     <= '0;
      cyc_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      acc_q    <= acc_d;
      gp_q     <= gp_d;
      cyc_q    <= cyc_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign acc00_o_accbank = acc_q[0];
  assign acc01_o_accbank = acc_q[1];
  assign acc02_o_accbank = acc_q[2];
  assign acc03_o_accbank = acc_q[3];
  assign acc04_o_accbank = acc_q[4];
  assign acc05_o_accbank = acc_q[5];
  assign acc06_o_accbank = acc_q[6];
  assign acc07_o_accbank = acc_q[7];
  assign acc08_o_accbank = acc_q[8];
  assign acc09_o_accbank = acc_q[9];
  assign acc10_o_accbank = acc_q[10];
  assign acc11_o_accbank = acc_q[11];
  assign acc12_o_accbank = acc_q[12];
  assign acc13_o_accbank = acc_q[13];
  assign acc14_o_accbank = acc_q[14];
  assign acc15_o_accbank = acc_q[15];

  assign sysreg00_o_accbank = sys_view[0];
  assign sysreg01_o_accbank = sys_view[1];
  assign sysreg02_o_accbank = sys_view[2];
  assign sysreg03_o_accbank = sys_view[3];
  assign sysreg04_o_accbank = sys_view[4];
  assign sysreg05_o_accbank = sys_view[5];
  assign sysreg06_o_accbank = sys_view[6];
  assign sysreg07_o_accbank = sys_view[7];

endmodule

// File: tb/tb_acc_bank1.sv
// Directed, table-driven bench for acc_bank1 with hand-written host handshake sequences.
module tb_acc_bank1;

  logic        clk;
  logic        rst_n;
  logic [4:0]  acc_wen;
  logic [31:0] acc_wdata;
  logic        clr;
  logic        host_req, host_we, host_sel;
  logic [3:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic [31:0] acc_o [16];
  logic [31:0] sys_o [8];

  int checks = 0;
  int errors = 0;

  logic [31:0] acc_m [16];
  logic [31:0] exp_wr;
  logic [31:0] cyc_m;

  typedef struct {
    logic [4:0]  wen;
    logic [31:0] wdata;
    logic        clr;
    logic [31:0] exp_wr;
  } vec_t;
  vec_t vecs [8];

  acc_bank1 dut (
    .clk_i_accbank          (clk),
    .rst_n_i_accbank        (rst_n),
    .acc_wen_vctr_i_accbank (acc_wen),
    .acc_wdata_i_accbank    (acc_wdata),
    .clr_i_accbank          (clr),
    .host_req_i_accbank     (host_req),
    .host_we_i_accbank      (host_we),
    .host_sel_i_accbank     (host_sel),
    .host_addr_i_accbank    (host_addr),
    .host_wdata_i_accbank   (host_wdata),
    .host_ack_o_accbank     (host_ack),
    .host_rdata_o_accbank   (host_rdata),
    .acc00_o_accbank        (acc_o[0]),
    .acc01_o_accbank        (acc_o[1]),
    .acc02_o_accbank        (acc_o[2]),
    .acc03_o_accbank        (acc_o[3]),
    .acc04_o_accbank        (acc_o[4]),
    .acc05_o_accbank        (acc_o[5]),
    .acc06_o_accbank        (acc_o[6]),
    .acc07_o_accbank        (acc_o[7]),
    .acc08_o_accbank        (acc_o[8]),
    .acc09_o_accbank        (acc_o[9]),
    .acc10_o_accbank        (acc_o[10]),
    .acc11_o_accbank        (acc_o[11]),
    .acc12_o_accbank        (acc_o[12]),
    .acc13_o_accbank        (acc_o[13]),
    .acc14_o_accbank        (acc_o[14]),
    .acc15_o_accbank        (acc_o[15]),
    .sysreg00_o_accbank     (sys_o[0]),
    .sysreg01_o_accbank     (sys_o[1]),
    .sysreg02_o_accbank     (sys_o[2]),
    .sysreg03_o_accbank     (sys_o[3]),
    .sysreg04_o_accbank     (sys_o[4]),
    .sysreg05_o_accbank     (sys_o[5]),
    .sysreg06_o_accbank     (sys_o[6]),
    .sysreg07_o_accbank     (sys_o[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: counts edges out of reset, independent of the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_m <= '0;
    else        cyc_m <= cyc_m + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_accs(input string name);
    for (int i = 0; i < 16; i++) check($sformatf("%s_acc%0d", name, i), acc_o[i], acc_m[i]);
  endtask

  task automatic host_xfer(input logic we, input logic sel, input logic [3:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output int ncyc);
    host_req   = 1'b1;
    host_we    = we;
    host_sel   = sel;
    host_addr  = addr;
    host_wdata = wd;
    ncyc = 0;
    do begin
      step();
      ncyc++;
    end while (!host_ack && ncyc < 20);
    rd = host_rdata;
    if (!host_ack) begin
      checks++;
      errors++;
      $display("FAIL host_ack_timeout actual=0 expected=1 after %0d cycles", ncyc);
    end
    host_req = 1'b0;
    host_we  = 1'b0;
    step();
    check("ack_fall", {31'b0, host_ack}, 32'd0);
  endtask

  logic [31:0] rd;
  int          n;
  logic [31:0] n_exp;

  initial begin
    vecs[0] = '{5'b1_0011, 32'hDEADBEEF, 1'b0, 32'd1};
    vecs[1] = '{5'b0_0101, 32'h00001234, 1'b0, 32'd1};
    vecs[2] = '{5'b1_0000, 32'h00000011, 1'b0, 32'd2};
    vecs[3] = '{5'b1_1111, 32'hFFFF0000, 1'b0, 32'd3};
    vecs[4] = '{5'b1_0011, 32'hCAFEF00D, 1'b0, 32'd4};
    vecs[5] = '{5'b1_0001, 32'h77777777, 1'b1, 32'd4};
    vecs[6] = '{5'b1_0001, 32'h00000001, 1'b0, 32'd5};
    vecs[7] = '{5'b0_0000, 32'h00000000, 1'b1, 32'd5};

    rst_n = 1'b0;
    acc_wen = '0; acc_wdata = '0; clr = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_sel = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 16; i++) acc_m[i] = '0;
    exp_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, host_ack}, 32'd0);
    check("rst_rdata", host_rdata, 32'd0);
    check("rst_sys00", sys_o[0], 32'd0);
    check("rst_sys05", sys_o[5], 32'd0);
    check_accs("rst");
    rst_n = 1'b1;
    step();

    // Pipeline write / clear vectors
    for (int v = 0; v < 8; v++) begin
      acc_wen   = vecs[v].wen;
      acc_wdata = vecs[v].wdata;
      clr       = vecs[v].clr;
      if (vecs[v].clr) begin
        for (int i = 0; i < 16; i++) acc_m[i] = '0;
      end else if (vecs[v].wen[4]) begin
        acc_m[vecs[v].wen[3:0]] = vecs[v].wdata;
      end
      step();
      acc_wen = '0; clr = 1'b0;
      check_accs($sformatf("vec%0d", v));
      check($sformatf("vec%0d_wrcnt", v), sys_o[1], vecs[v].exp_wr);
    end
    exp_wr = 32'd5;
    check("cyc_count", sys_o[0], cyc_m);

    // Host acc write held off by three pipeline-write cycles
    acc_wen = 5'b1_0010; acc_wdata = 32'h0BAD0001;
    host_req = 1'b1; host_we = 1'b1; host_sel = 1'b0; host_addr = 4'd7; host_wdata = 32'hA5A5A5A5;
    n = 0;
    repeat (3) begin
      step();
      n++;
      check("ack_held_off", {31'b0, host_ack}, 32'd0);
    end
    acc_wen = '0;
    exp_wr = exp_wr + 3;
    acc_m[2] = 32'h0BAD0001;
    while (!host_ack && n < 20) begin
      step();
      n++;
    end
    check("acc_wr_latency", n, 32'd4);
    acc_m[7] = 32'hA5A5A5A5;
    check("acc07_host", acc_o[7], 32'hA5A5A5A5);
    check("acc02_pipe", acc_o[2], 32'h0BAD0001);
    check("wrcnt_after_host", sys_o[1], exp_wr);
    host_req = 1'b0; host_we = 1'b0;
    step();
    check("ack_fall_acc", {31'b0, host_ack}, 32'd0);

    // Read cycle counter: value captured is the counter during XFER
    host_req = 1'b1; host_we = 1'b0; host_sel = 1'b1; host_addr = 4'd0;
    step();
    n_exp = cyc_m;
    check("cyc_in_xfer", sys_o[0], n_exp);
    step();
    check("rd_ack", {31'b0, host_ack}, 32'd1);
    check("rd_sys00", host_rdata, n_exp);
    host_req = 1'b0;
    step();
    check("rd_ack_fall", {31'b0, host_ack}, 32'd0);

    // Writes to counters are ignored but still acked
    host_xfer(1'b1, 1'b1, 4'd0, 32'h00000000, rd, n);
    check("wr_sys00_latency", n, 32'd2);
    check("sys00_counting", sys_o[0], cyc_m);
    host_xfer(1'b1, 1'b1, 4'd1, 32'h12340000, rd, n);
    check("sys01_ignored", sys_o[1], exp_wr);

    // General-purpose sysregs and out-of-range addresses
    host_xfer(1'b1, 1'b1, 4'd5, 32'h55AA1234, rd, n);
    check("sys05_wr", sys_o[5], 32'h55AA1234);
    check("sys02_untouched", sys_o[2], 32'd0);
    host_xfer(1'b1, 1'b1, 4'd12, 32'hFFFFFFFF, rd, n);
    check("oor_wr_sys04", sys_o[4], 32'd0);
    check("oor_wr_latency", n, 32'd2);
    host_xfer(1'b0, 1'b1, 4'd5, 32'd0, rd, n);
    check("rd_sys05", rd, 32'h55AA1234);
    host_xfer(1'b0, 1'b1, 4'd9, 32'd0, rd, n);
    check("rd_sys_oor", rd, 32'd0);
    host_xfer(1'b0, 1'b0, 4'd3, 32'd0, rd, n);
    check("rd_acc03", rd, acc_m[3]);
    host_xfer(1'b0, 1'b0, 4'd7, 32'd0, rd, n);
    check("rd_acc07", rd, 32'hA5A5A5A5);
    check_accs("post_host");

    // Write-counter saturation
    force dut.wr_cnt_q = 32'hFFFFFFFE;
    #2;
    release dut.wr_cnt_q;
    #1;
    check("wrcnt_preload", sys_o[1], 32'hFFFFFFFE);
    for (int k = 0; k < 3; k++) begin
      acc_wen = 5'b1_0100; acc_wdata = 32'h100 + k;
      step();
      check($sformatf("wrcnt_sat%0d", k), sys_o[1], 32'hFFFFFFFF);
    end
    acc_wen = '0;
    acc_m[4] = 32'h102;
    check("acc04_last", acc_o[4], acc_m[4]);

    // Asynchronous reset in the middle of a read transfer
    host_req = 1'b1; host_we = 1'b0; host_sel = 1'b0; host_addr = 4'd7;
    step();
    rst_n = 1'b0;
    #1;
    host_req = 1'b0;
    for (int i = 0; i < 16; i++) acc_m[i] = '0;
    check("arst_ack", {31'b0, host_ack}, 32'd0);
    check("arst_rdata", host_rdata, 32'd0);
    check("arst_sys00", sys_o[0], 32'd0);
    check("arst_sys01", sys_o[1], 32'd0);
    check("arst_sys05", sys_o[5], 32'd0);
    check_accs("arst");
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_no_ack", {31'b0, host_ack}, 32'd0);
    check("post_rst_rdata", host_rdata, 32'd0);
    check("post_rst_cyc", sys_o[0], cyc_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_bank1.md
Name: acc_bank1

Overview:
- Accumulator/system-register file for the Int1 execution lane. It is the write end of the accumulator interface and the source of the acc/sysreg read buses.
- Consumes the 5-bit write-enable vector and write data that the Int1 stage produces. Drives acc00..acc15 and sysreg00..sysreg07 back into that stage.
- Adds a four-phase host/debug port for inspecting and loading registers, a synchronous bulk clear, and two hardware counters in the sysreg space.

Parameters:
- DW, 32, data width of every acc/sysreg.
- NACC, 16, number of accumulators; fixed by the 4-bit index field.
- NSYS, 8, number of system registers.

Ports:
- clk_i_accbank  in  1  single clock, rising edge.
- rst_n_i_accbank  in  1  asynchronous, active-low reset.
- acc_wen_vctr_i_accbank  in  5  bit4 = write enable, bits[3:0] = acc index.
- acc_wdata_i_accbank  in  32  write data for the pipeline write.
- clr_i_accbank  in  1  synchronous clear of all 16 accs.
- host_req_i_accbank  in  1  host request; held until ack, then dropped.
- host_we_i_accbank  in  1  1 = write, 0 = read; sampled in IDLE with req.
- host_sel_i_accbank  in  1  0 = acc space, 1 = sysreg space.
- host_addr_i_accbank  in  4  register index.
- host_wdata_i_accbank  in  32  host write data.
- host_ack_o_accbank  out  1  high while in ACK.
- host_rdata_o_accbank  out  32  read data, valid while ack = 1.
- acc00_o_accbank..acc15_o_accbank  out  32 each  registered acc values.
- sysreg00_o_accbank..sysreg07_o_accbank  out  32 each  registered sysreg values.

Behaviour:
- Reset (async, rst_n = 0):
  - all accs, sysregs, host_rdata, host_ack = 0; FSM = IDLE; host request capture registers = 0.
  - Reset mid-transfer aborts it; after release the host must re-issue its request.
- Pipeline write:
  - wen[4] = 1 writes acc[wen[3:0]] <= wdata at the next edge; the new value is visible on the acc output one cycle later.
  - No read bypass.
  - wen[4] = 0 means no write; index bits are ignored.
- Clear: clr = 1 zeros all accs at the next edge. A pipeline write in the same cycle is dropped and does not increment sysreg01.
- sysreg00: free-running cycle counter, +1 every cycle, wraps 0xFFFFFFFF -> 0. Host writes are ignored.
- sysreg01:
  - counts accepted pipeline writes; saturates at 0xFFFFFFFF.
  - Host writes are ignored.
  - Clear does not reset it.
- sysreg02..07: plain registers, written only by the host.
- Host FSM, four-phase handshake:
  - IDLE: when req = 1, capture we/sel/addr/wdata and go to XFER.
  - XFER, read:
    - host_rdata <= the selected register's current value (pre-edge); go to ACK.
    - sysreg space with addr[3] = 1 returns 0.
  - XFER, write to acc space:
    - Performed only in a cycle with no pipeline write (wen[4] = 0) and clr = 0.
    - Otherwise the FSM stays in XFER. Pipeline and clear always have priority.
  - XFER, write to sysreg space:
    - performed immediately for 02..07;
    - ignored for 00, 01 and out-of-range addresses; the FSM still goes to ACK.
  - ACK: ack = 1; stay until req = 0, then go to IDLE. ack deasserts the cycle after req falls.
- Captured request fields are stable from IDLE exit until IDLE re-entry. Input changes during XFER/ACK are ignored.
- Starvation of host acc writes under continuous pipeline writes is permitted; the pipeline stage never stalls.

Decomposition:
- Shared package (acc_bank_pkg):
  - DW/NACC/NSYS constants;
  - FSM state encoding (IDLE = 2'b00, XFER = 2'b01, ACK = 2'b10);
  - WEN_VLD_BIT = 4.
- One natural sub-module: acc_bank_host_if1, holding the host FSM, request capture and rdata mux.
- Register arrays and counters live in the top module.

Test Plan:
- Reset, then wen = 5'b1_0011, wdata = 0xDEADBEEF -> acc03 = 0xDEADBEEF one cycle after the edge; others 0; sysreg01 = 1.
- wen = 5'b0_0101, wdata = 0x1234 -> no acc changes; sysreg01 unchanged.
- clr = 1 together with wen = 5'b1_0001 -> all accs 0; sysreg01 unchanged.
- Host write acc07 = 0xA5A5A5A5 while wen[4] = 1 for 3 cycles -> ack delayed until the first idle cycle; acc07 = 0xA5A5A5A5; host holds req until ack, then drops it; ack falls the next cycle.
- Host read sysreg sel = 1, addr = 0 at counter value N -> rdata = N captured in XFER. Host write to sysreg00 -> acked, value keeps counting. Host read sysreg addr = 9 -> rdata = 0.
- Force sysreg01 to 0xFFFFFFFE, issue 3 pipeline writes -> saturates at 0xFFFFFFFF. Assert rst_n = 0 during XFER -> FSM IDLE, ack 0, all regs 0 immediately.
